scan_risk_loader: RTL and testbench

SCAN_RISK_LOADER -- requirements
Module: scan_risk_loader

---
 rtl/scan_risk_loader_if.sv | 20 ++
 rtl/scan_risk_loader.sv | 151 +++++++++++++++
 tb/tb_scan_risk_loader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/scan_risk_loader_if.sv
// Word-stream input and result output handshake bundle for scan_risk_loader.
// The loader takes the slave side; the upstream source and result consumer take the master side.
interface scan_risk_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] result_data;

    modport master (
        output in_valid, in_data, result_ready,
        input  in_ready, result_valid, result_data
    );

    modport slave (
        input  in_valid, in_data, result_ready,
        output in_ready, result_valid, result_data
    );
endinterface

// File: rtl/scan_risk_loader.sv
// Loads a price-scan-range word plus eight positions, runs the scanning-risk block for LATENCY cycles
// and holds its result until taken. Optional macro LOADER_NETPOS_EN skips RUN for a non-positive net position.
module scan_risk_loader #(
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    scan_risk_loader_if.slave  bus,
    output logic [15:0]        priceScanRange,
    output logic [15:0]        position [0:7],
    output logic               calc_run,
    input  logic [15:0]        risk_in
);
    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

    logic [1:0]  state_r;
    logic [1:0]  state_s;
    logic [3:0]  word_cnt_r;
    logic [3:0]  lat_cnt_r;
    logic        in_ready_r;
    logic        calc_run_r;
    logic        result_valid_r;
    logic [15:0] result_r;
    logic [15:0] psr_r;
    logic [15:0] pos_r [0:7];
    logic        word_take_s;
    logic        last_word_s;
    logic        run_end_s;
    logic        result_take_s;
    logic        skip_run_s;

`ifdef LOADER_NETPOS_EN
    logic [15:0] net_r;
    logic [15:0] net_s;

    function automatic logic is_nonpositive(input logic [15:0] v);
        return (v == 16'd0) || v[15];
    endfunction
`endif

    // Handshake qualifiers for the current cycle
    always_comb begin
        word_take_s   = bus.in_valid && in_ready_r && (state_r == ST_LOAD);
        last_word_s   = word_take_s && (word_cnt_r == 4'd8);
        run_end_s     = (state_r == ST_RUN) && (lat_cnt_r == LAT_LAST);
        result_take_s = (state_r == ST_DONE) && result_valid_r && bus.result_ready;
`ifdef LOADER_NETPOS_EN
        net_s         = net_r + bus.in_data;
        skip_run_s    = last_word_s && is_nonpositive(net_s);
`else
        skip_run_s    = 1'b0;
`endif
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (last_word_s) state_s = skip_run_s ? ST_DONE : ST_RUN;
                else             state_s = ST_LOAD;
            end
            ST_RUN: begin
                if (run_end_s) state_s = ST_DONE;
                else           state_s = ST_RUN;
            end
            ST_DONE: begin
                if (result_take_s) state_s = ST_LOAD;
                else               state_s = ST_DONE;
            end
            default: state_s = ST_LOAD;
        endcase
    end

    // State and registered handshake/control outputs, all decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_LOAD;
            in_ready_r     <= 1'b0;
            calc_run_r     <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            in_ready_r     <= (state_s == ST_LOAD);
            calc_run_r     <= (state_s == ST_RUN);
            result_valid_r <= (state_s == ST_DONE);
        end
    end

    // Word and latency counters; the word counter stalls while in_valid is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt_r <= 4'd0;
            lat_cnt_r  <= 4'd0;
        end else begin
            if (last_word_s)      word_cnt_r <= 4'd0;
            else if (word_take_s) word_cnt_r <= word_cnt_r + 4'd1;
            else                  word_cnt_r <= word_cnt_r;

            if (state_r != ST_RUN) lat_cnt_r <= 4'd0;
            else if (run_end_s)    lat_cnt_r <= 4'd0;
            else                   lat_cnt_r <= lat_cnt_r + 4'd1;
        end
    end

    // Operand capture; registers keep their contents until a new word lands on them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psr_r <= 16'd0;
            for (int i = 0; i < 8; i++) pos_r[i] <= 16'd0;
        end else if (word_take_s) begin
            case (word_cnt_r)
                4'd0:    psr_r <= bus.in_data;
                4'd1, 4'd2, 4'd3, 4'd4,
                4'd5, 4'd6, 4'd7, 4'd8:
                         pos_r[word_cnt_r[2:0] - 3'd1] <= bus.in_data;
                default: psr_r <= psr_r;
            endcase
        end else begin
            psr_r <= psr_r;
        end
    end

    // Result capture: risk_in at the end of RUN, or zero when RUN is skipped
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          result_r <= 16'd0;
        else if (last_word_s && skip_run_s) result_r <= 16'd0;
        else if (run_end_s)                 result_r <= risk_in;
        else                                result_r <= result_r;
    end

`ifdef LOADER_NETPOS_EN
    // Net-position accumulator, restarted by word 0 of each set
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                    net_r <= 16'd0;
        else if (word_take_s && word_cnt_r == 4'd0)   net_r <= 16'd0;
        else if (word_take_s)                         net_r <= net_s;
        else                                          net_r <= net_r;
    end
`endif

    assign bus.in_ready     = in_ready_r;
    assign bus.result_valid = result_valid_r;
    assign bus.result_data  = result_r;
    assign calc_run         = calc_run_r;
    assign priceScanRange   = psr_r;
    assign position         = pos_r;
endmodule

// File: tb/tb_scan_risk_loader.sv
// Randomized self-checking bench for scan_risk_loader; emulates the scanning-risk block and
// predicts each result from the words sent. Honours LOADER_NETPOS_EN when defined.
module tb_scan_risk_loader;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] priceScanRange;
    logic [15:0] position [0:7];
    logic        calc_run;
    logic [15:0] risk_in;
    int          errors = 0;
    int          checks = 0;
    int          run_cnt = 0;
    logic [15:0] words [0:8];

    scan_risk_loader_if bus();

    scan_risk_loader #(.LATENCY(LAT)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .priceScanRange (priceScanRange),
        .position       (position),
        .calc_run       (calc_run),
        .risk_in        (risk_in)
    );

    always #5 clk = ~clk;

    // Scanning-risk block stand-in: only the LAT-th cycle of calc_run carries a real answer
    always @(posedge clk) run_cnt <= calc_run ? run_cnt + 1 : 0;

    always_comb begin
        logic [15:0] s;
        s = 16'd0;
        for (int i = 0; i < 8; i++) s = s + position[i];
        risk_in = (calc_run && run_cnt == LAT - 1) ? 16'(priceScanRange * s) : 16'hDEAD;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] net_pos();
        logic [15:0] s;
        s = 16'd0;
        for (int i = 1; i < 9; i++) s = s + words[i];
        return s;
    endfunction

    function automatic bit model_skip();
`ifdef LOADER_NETPOS_EN
        logic [15:0] s;
        s = net_pos();
        return (s == 16'd0) || s[15];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] model_result();
        return model_skip() ? 16'd0 : 16'(words[0] * net_pos());
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", bus.in_ready, 1'b0);
        check_eq("rst_calc_run", calc_run, 1'b0);
        check_eq("rst_valid", bus.result_valid, 1'b0);
        check_eq("rst_result", bus.result_data, 16'd0);
        check_eq("rst_psr", priceScanRange, 16'd0);
        for (int i = 0; i < 8; i++) check_eq("rst_position", position[i], 16'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", bus.in_ready, 1'b1);
        check_eq("post_rst_valid", bus.result_valid, 1'b0);
    endtask

    // gaps: 0 none, 1 one idle cycle before every word, 2 random idle cycles
    task automatic run_set(input int gaps, input int hold);
        logic [15:0] exp_res;
        int          exp_cyc;
        int          cyc;
        int          runs;
        exp_res = model_result();
        exp_cyc = model_skip() ? 0 : LAT;
        for (int w = 0; w < 9; w++) begin
            if (gaps == 1) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 16'($urandom);
                @(negedge clk);
            end else if (gaps == 2) begin
                while ($urandom_range(0, 1) == 0) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = 16'($urandom);
                    @(negedge clk);
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = words[w];
            check_eq("in_ready_load", bus.in_ready, 1'b1);
            @(negedge clk);
        end
        bus.in_valid     = 1'b1;
        bus.in_data      = 16'hBAD0;
        bus.result_ready = 1'b0;
        cyc  = 0;
        runs = 0;
        while (!bus.result_valid && cyc < 40) begin
            check_eq("in_ready_busy", bus.in_ready, 1'b0);
            if (calc_run) runs++;
            @(negedge clk);
            cyc++;
        end
        check_eq("done_latency", cyc, exp_cyc);
        check_eq("run_cycles", runs, exp_cyc);
        check_eq("result_data", bus.result_data, exp_res);
        check_eq("psr_held", priceScanRange, words[0]);
        for (int i = 0; i < 8; i++) check_eq("position_held", position[i], words[i + 1]);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_valid", bus.result_valid, 1'b1);
            check_eq("hold_data", bus.result_data, exp_res);
            check_eq("hold_in_ready", bus.in_ready, 1'b0);
            check_eq("hold_calc_run", calc_run, 1'b0);
        end
        bus.result_ready = 1'b1;
        bus.in_data      = 16'hBAD1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        bus.in_valid     = 1'b0;
        check_eq("valid_drop", bus.result_valid, 1'b0);
        check_eq("ready_back", bus.in_ready, 1'b1);
        check_eq("no_early_take", priceScanRange, words[0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_data      = 16'd0;
        bus.result_ready = 1'b0;
        reset            = 1'b1;
        @(negedge clk);
        do_reset();

        words[0] = 16'd100;
        for (int i = 1; i < 9; i++) words[i] = 16'd1;
        run_set(0, 3);
        run_set(1, 0);

        words[0] = 16'd77;
        words[1] = 16'd5;
        words[2] = 16'hFFFB;
        for (int i = 3; i < 9; i++) words[i] = 16'd0;
        run_set(0, 1);

        words[0] = 16'd12;
        for (int i = 1; i < 9; i++) words[i] = 16'(i);
        for (int w = 0; w < 5; w++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h5A5A;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        do_reset();
        run_set(0, 10);

        for (int k = 0; k < 3; k++) begin
            words[0] = 16'($urandom_range(1, 500));
            for (int i = 1; i < 9; i++) words[i] = 16'($urandom_range(0, 50));
            run_set(0, 0);
        end

        for (int k = 0; k < 20; k++) begin
            words[0] = 16'($urandom);
            for (int i = 1; i < 9; i++) words[i] = 16'($urandom);
            run_set($urandom_range(0, 2), $urandom_range(0, 10));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
